// File: rtl/fp_acc_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fp_acc_seq (with its private adder, fp_adder2)             |
// | Description : Reduces a stream of cfg_len floating-point operands, one   |
// |               per cycle, to a single sum using one combinational 2-input |
// |               adder. Start/length control, valid/ready on both sides and |
// |               a held result.                                             |
// | Ports       : clk, rst (async, active-high)                              |
// |               start, cfg_len          - launch a reduction (IDLE only)   |
// |               in_valid/in_ready/in_data   - operand stream               |
// |               out_valid/out_ready/out_data - result, held until taken    |
// |               busy                    - high while ACC or OUT            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

// Combinational adder. No denormals: exponent 0 still carries a hidden 1.
// Two guard bits below the mantissa, rounding adds 2'b10 there (half-up on
// magnitude). Overflow saturates to exponent all-ones / mantissa 0; underflow
// and exact cancellation flush to zero with the sign of the signed sum.
module fp_adder2 #(
  parameter int EXPONENT = 5,
  parameter int MANTISSA = 10
) (
  input  logic [EXPONENT+MANTISSA:0] a,
  input  logic [EXPONENT+MANTISSA:0] b,
  output logic [EXPONENT+MANTISSA:0] y
);
  localparam int W    = EXPONENT + MANTISSA + 1;
  localparam int SW   = MANTISSA + 3;          // hidden bit + mantissa + 2 guard
  localparam int EMAX = (1 << EXPONENT) - 1;

  logic [W-1:0]         w_big, w_small;
  logic [EXPONENT-1:0]  w_diff;
  logic [SW-1:0]        w_m_big, w_m_small, w_norm;
  logic signed [SW+1:0] w_s_big, w_s_small, w_s_sum;
  logic [SW:0]          w_mag, w_rnd;
  logic [MANTISSA-1:0]  w_mant;
  logic                 w_sign;
  int                   w_lead, w_exp;

  always_comb begin
    // Order operands by magnitude so the alignment shift is always rightward.
    if (a[W-2:0] >= b[W-2:0]) begin
      w_big   = a;
      w_small = b;
    end else begin
      w_big   = b;
      w_small = a;
    end
    w_diff    = w_big[W-2:MANTISSA] - w_small[W-2:MANTISSA];
    w_m_big   = {1'b1, w_big[MANTISSA-1:0], 2'b00};
    w_m_small = {1'b1, w_small[MANTISSA-1:0], 2'b00} >> w_diff;
    w_s_big   = w_big[W-1]   ? -$signed({2'b00, w_m_big})   : $signed({2'b00, w_m_big});
    w_s_small = w_small[W-1] ? -$signed({2'b00, w_m_small}) : $signed({2'b00, w_m_small});
    w_s_sum   = w_s_big + w_s_small;
    w_sign    = w_s_sum[SW+1];
    w_mag     = (SW+1)'(w_sign ? -w_s_sum : w_s_sum);

    w_lead = 0;
    for (int i = 0; i <= SW; i++) begin
      if (w_mag[i]) w_lead = i;
    end
    // Normalise so the leading one sits at the hidden-bit position SW-1.
    w_exp = int'(w_big[W-2:MANTISSA]) + w_lead - (SW - 1);
    if (w_lead == SW) w_norm = SW'(w_mag >> 1);
    else              w_norm = SW'(w_mag << (SW - 1 - w_lead));

    w_rnd = {1'b0, w_norm} + (SW+1)'(2);
    if (w_rnd[SW]) begin
      w_rnd = w_rnd >> 1;
      w_exp = w_exp + 1;
    end
    w_mant = MANTISSA'(w_rnd >> 2);

    if (w_mag == '0 || w_exp < 0) y = {w_sign, {(W-1){1'b0}}};
    else if (w_exp >= EMAX)       y = {w_sign, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
    else                          y = {w_sign, EXPONENT'(w_exp), w_mant};
  end
endmodule

module fp_acc_seq #(
  parameter int EXPONENT  = 5,
  parameter int MANTISSA  = 10,
  parameter int LEN_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         cfg_len,
  input  logic                         in_valid,
  input  logic [EXPONENT+MANTISSA:0]   in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [EXPONENT+MANTISSA:0]   out_data,
  input  logic                         out_ready,
  output logic                         busy
);
  localparam int W = EXPONENT + MANTISSA + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACC  = 2'b01,
    S_OUT  = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         acc_q, acc_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic                 first_q, first_d;
  logic [W-1:0]         w_sum;

  fp_adder2 #(
    .EXPONENT (EXPONENT),
    .MANTISSA (MANTISSA)
  ) u_add (
    .a (acc_q),
    .b (in_data),
    .y (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_len != '0) begin
            remaining_d = cfg_len;
            first_d     = 1'b1;
            state_d     = S_ACC;
          end else begin
            acc_d   = '0;
            state_d = S_OUT;
          end
        end
      end
      S_ACC: begin
        if (in_valid) begin
          // The first operand is loaded directly: the adder has no true zero,
          // so seeding it with +0 would perturb the sum.
          acc_d       = first_q ? in_data : w_sum;
          first_d     = 1'b0;
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = acc_q;
  assign busy      = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_fp_acc_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fp_acc_seq                                              |
// | Description : Self-checking bench for fp_acc_seq: vector table, reset,   |
// |               backpressure and randomized reductions vs. an integer      |
// |               reference model.                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fp_acc_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  cfg_len = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0]        len;
    logic [7:0][15:0]  ops;
    logic [7:0][3:0]   gaps;
    logic [15:0]       exp;
    logic [3:0]        odly;
  } vec_t;

  vec_t             tbl[6];
  logic [7:0][15:0] r_ops;
  logic [7:0][3:0]  r_gaps;

  fp_acc_seq #(.EXPONENT(5), .MANTISSA(10), .LEN_WIDTH(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  // Reference: value in quarter units (q/4) encoded as a half-precision word.
  function automatic logic [15:0] to_half(input int q);
    int  m, e;
    logic s;
    if (q == 0) return 16'h0000;
    s = (q < 0);
    m = s ? -q : q;
    e = 0;
    for (int i = 0; i < 30; i++) if (m >= (1 << i)) e = i;
    return {s, 5'(e + 13), 10'((m << 10) >> e)};
  endfunction

  function automatic vec_t mk(input int len, input logic [15:0] o0, o1, o2, o3,
                              input int g0, g1, g2, input logic [15:0] exp, input int odly);
    vec_t v;
    v = '0;
    v.len = 10'(len);
    v.ops[0] = o0; v.ops[1] = o1; v.ops[2] = o2; v.ops[3] = o3;
    v.gaps[0] = 4'(g0); v.gaps[1] = 4'(g1); v.gaps[2] = 4'(g2);
    v.exp = exp;
    v.odly = 4'(odly);
    return v;
  endfunction

  // One full reduction: start, feed operands with gaps, check result timing,
  // hold the result for odly cycles (with start pulses), then take it.
  task automatic run_red(input string tag, input int len, input logic [7:0][15:0] ops,
                         input logic [7:0][3:0] gaps, input logic [15:0] exp, input int odly);
    int idx, gap_left, cyc, bad, hold_bad;
    @(negedge clk);
    start = 1'b1;
    cfg_len = 10'(len);
    @(negedge clk);
    start = 1'b0;
    cfg_len = 10'($urandom_range(0, 1023));
    idx = 0; cyc = 0; bad = 0;
    gap_left = int'(gaps[0]);
    while (idx < len && cyc < 200) begin
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) bad++;
      if (gap_left > 0) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        gap_left--;
      end else begin
        in_valid = 1'b1;
        in_data  = ops[idx];
        idx++;
        if (idx < len) gap_left = int'(gaps[idx]);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    check(tag, "timeout", 32'(cyc >= 200), 32'd0);
    check(tag, "acc_phase", 32'(bad), 32'd0);
    check(tag, "out_valid", {31'd0, out_valid}, 32'd1);
    check(tag, "out_data", {16'd0, out_data}, {16'd0, exp});
    check(tag, "out_in_ready", {31'd0, in_ready}, 32'd0);
    hold_bad = 0;
    for (int i = 0; i < odly; i++) begin
      start = 1'b1;
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== exp || busy !== 1'b1) hold_bad++;
    end
    check(tag, "hold_stable", 32'(hold_bad), 32'd0);
    start = 1'($urandom_range(0, 1));
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    check(tag, "taken_busy", {31'd0, busy}, 32'd0);
    check(tag, "taken_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int len, q, k;
    logic [15:0] e;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset", "in_ready", {31'd0, in_ready}, 32'd0);
    check("reset", "out_valid", {31'd0, out_valid}, 32'd0);
    check("reset", "out_data", {16'd0, out_data}, 32'd0);
    check("reset", "busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    tbl[0] = mk(4, 16'h3C00, 16'h4000, 16'h4200, 16'h3800, 0, 0, 0, 16'h4680, 0);
    tbl[1] = mk(2, 16'h3C00, 16'hBC00, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0);
    tbl[2] = mk(3, 16'h3C00, 16'h4000, 16'h4200, 16'h0000, 0, 0, 0, 16'h4600, 0);
    tbl[3] = mk(3, 16'h3C00, 16'h4000, 16'h4200, 16'h0000, 0, 2, 5, 16'h4600, 0);
    tbl[4] = mk(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0);
    tbl[5] = mk(1, 16'h3C00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h3C00, 10);
    for (int i = 0; i < 6; i++) begin
      run_red($sformatf("vec%0d", i), int'(tbl[i].len), tbl[i].ops, tbl[i].gaps,
              tbl[i].exp, int'(tbl[i].odly));
    end

    // Asynchronous reset in the middle of a 4-operand reduction.
    @(negedge clk);
    start = 1'b1; cfg_len = 10'd4;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h3C00;
    @(negedge clk);
    in_data = 16'h4000;
    @(negedge clk);
    in_valid = 1'b0;
    check("midrst", "pre_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst", "pre_out_data", {16'd0, out_data}, 32'h4200);
    #2 rst = 1'b1;
    #1;
    check("midrst", "in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst", "busy", {31'd0, busy}, 32'd0);
    check("midrst", "out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst", "out_data", {16'd0, out_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    r_ops = '0; r_gaps = '0;
    r_ops[0] = 16'h3C00;
    run_red("post_rst", 1, r_ops, r_gaps, 16'h3C00, 0);

    // Randomized reductions against an exact quarter-unit integer model.
    for (int r = 0; r < 25; r++) begin
      len = int'($urandom_range(1, 8));
      q = 0;
      r_ops = '0; r_gaps = '0;
      for (int i = 0; i < len; i++) begin
        k = int'($urandom_range(1, 64));
        if ($urandom_range(0, 1) == 1) k = -k;
        r_ops[i]  = to_half(k);
        r_gaps[i] = 4'($urandom_range(0, 2));
        q += k;
      end
      e = to_half(q);
      run_red($sformatf("rand%0d", r), len, r_ops, r_gaps, e, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fp_acc_seq.md
Name: fp_acc_seq

Overview:
- Sequencer that owns one 2-operand floating-point adder (fp_adder2, combinational) and drives it as a vector accumulator.
- Reduces a stream of cfg_len operands, one per cycle, to a single sum.
- Sits between the FC-layer multiplier array and the output buffer, turning per-lane product streams into partial sums.
- Adds the start/length control, valid/ready handshakes and result holding that fp_adder2 does not have.

Parameters:
EXPONENT, 5, exponent field width (passed to fp_adder2).
MANTISSA, 10, stored mantissa width (passed to fp_adder2); data width W = EXPONENT+MANTISSA+1.
LEN_WIDTH, 10, width of operand-count field; maximum vector length is 2^LEN_WIDTH-1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high.
start  input  1  pulse; begins a reduction. Sampled only in IDLE.
cfg_len  input  LEN_WIDTH  number of operands; latched when start is accepted.
in_valid  input  1  operand valid.
in_data  input  W  operand, same packing as fp_adder2.
in_ready  output  1  operand accepted when in_valid&in_ready.
out_valid  output  1  sum valid; held until taken.
out_data  output  W  accumulated sum.
out_ready  input  1  downstream accepts sum when out_valid&out_ready.
busy  output  1  high in ACC or OUT.

Behaviour:
- Reset (asynchronous, any state, including mid-reduction):
  - State goes to IDLE; the partial sum is discarded.
  - Accumulator register and remaining-count register clear to 0.
  - in_ready=0, out_valid=0, out_data=0, busy=0.
- States: IDLE, ACC, OUT (2-bit encoding; the unused code returns to IDLE).
- IDLE:
  - in_ready=0.
  - On start=1 with cfg_len!=0: latch remaining=cfg_len, set first=1, go to ACC.
  - On start=1 with cfg_len==0: load acc=0 (all-zero word) and go directly to OUT.
- ACC:
  - in_ready=1; each handshake consumes one operand.
  - First operand (first=1): acc <= in_data directly, not through the adder. fp_adder2 has no denormals and treats exponent 0 as a hidden-1 value, so adding to +0 would be inexact. Clear first.
  - Later operands: acc <= fp_adder2(acc, in_data), registered.
  - Each handshake decrements remaining. The handshake that brings remaining from 1 to 0 moves the block to OUT at the same edge.
  - in_valid=0 stalls: no state change, no count change.
  - Throughput is 1 operand/cycle.
  - start during ACC or OUT is ignored (no restart, no error).
- OUT:
  - out_valid=1, out_data=acc, in_ready=0.
  - out_valid rises the cycle after the last operand handshake; latency from last operand to result is 1 cycle.
  - Hold out_valid and out_data stable while out_ready=0.
  - On out_valid&out_ready: go to IDLE next edge; out_valid drops.
  - A new start is accepted from the following cycle at the earliest; start coincident with the output handshake is ignored.
- Arithmetic: exactly fp_adder2 semantics, unchanged.
  - Round by adding 2'b10 at the guard position.
  - Overflow gives exponent all-ones, mantissa 0.
  - Underflow or exact cancellation gives exponent 0, mantissa 0, sign taken from the adder's signed sum.
  - The sequencer never inspects or corrects results.
- Counter: remaining is LEN_WIDTH bits and never wraps (decrement only in ACC, where it is ≥1).
- busy = (state!=IDLE).
- Width rules: acc register is W bits; out_data is driven directly from acc (registered output, no combinational path from in_data).

Test Plan:
- Reset → all outputs 0, state IDLE; assert rst mid-ACC after 2 of 4 operands → in_ready low asynchronously, next start with cfg_len=1, in 16'h3C00 → out 16'h3C00.
- start, cfg_len=4, in 16'h3C00,16'h4000,16'h4200,16'h3800 back-to-back, out_ready=1 → out_valid exactly 1 cycle after 4th handshake, out_data=16'h4680 (6.5), busy low next cycle.
- cfg_len=2, in 16'h3C00 then 16'hBC00 → out_data=16'h0000.
- cfg_len=3 with in_valid gaps of 0,2,5 idle cycles → same result as gapless run, in_ready stays 1 throughout ACC, count unchanged during gaps.
- cfg_len=0 → out_valid next cycle with out_data=16'h0000, no operands consumed (in_ready never 1).
- Backpressure: complete cfg_len=1 reduction, hold out_ready=0 for 10 cycles with start pulses → out_valid/out_data stable, starts ignored; out_ready=1 → IDLE, then new start accepted.
